wb_arb2: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter, placed directly downstream of the RISC-V Wishbone BIU.
- Master 0 is the BIU instruction port (read-only). Master 1 is the BIU data port.
- Merges both onto a single shared Wishbone bus that feeds the SoC interconnect and memory.
- Round-robin grant; a grant is held until the slave acks or the owning master abandons its cycle.

---
 rtl/wb_arb_pkg.sv | 30 +++
 rtl/wb_arb2_if.sv | 42 ++++
 rtl/wb_arb_rr2.sv | 34 +++
 rtl/wb_arb2.sv | 189 ++++++++++++++++++
 tb/tb_wb_arb2.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared definitions for the two-master Wishbone classic arbiter (wb_arb2)
//   and its round-robin grant selector (wb_arb_rr2).
//
//   Contents:
//     arb_state_e  - arbiter FSM encoding (IDLE / GNT0 / GNT1)
//     M_INS, M_DAT - master index constants (instruction / data master)
//     SEL_ALL      - byte-select pattern used for every instruction fetch
//     TIMEOUT_DAT  - read data returned on a watchdog-terminated cycle
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // Master indices double as the encoding of the last-grant register and as
  // bit positions in the one-hot grant vector.
  localparam logic M_INS = 1'b0;
  localparam logic M_DAT = 1'b1;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] SEL_ALL = 4'hf;

  localparam logic [31:0] TIMEOUT_DAT = 32'h0;

endpackage

// File: rtl/wb_arb2_if.sv
// -----------------------------------------------------------------------------
// wb_arb2_if
//   One Wishbone classic port as seen by the arbiter. The same bundle is used
//   for both upstream masters and for the shared downstream bus.
//
//   Parameters: AW (address width), DW (data width)
//   Signals:
//     cyc, stb, we  - cycle, strobe, write enable (master -> slave)
//     sel[3:0]      - byte selects                 (master -> slave)
//     adr[AW-1:0]   - address                      (master -> slave)
//     dat_w[DW-1:0] - write data                   (master -> slave)
//     dat_r[DW-1:0] - read data                    (slave  -> master)
//     ack           - transfer acknowledge         (slave  -> master)
//   Modports:
//     mst - the side that issues cycles
//     slv - the side that answers them
// -----------------------------------------------------------------------------
interface wb_arb2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;

  modport mst (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slv (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/wb_arb_rr2.sv
// -----------------------------------------------------------------------------
// wb_arb_rr2
//   Two-request round-robin grant selector. Purely combinational.
//   A lone request is granted directly; on a tie the master that was NOT
//   granted last wins.
//
//   Ports:
//     req0     in  request from master 0 (M_INS)
//     req1     in  request from master 1 (M_DAT)
//     last_gnt in  index of the master that completed the previous transfer
//     gnt[1:0] out one-hot grant, bit index = master index (0 when idle)
// -----------------------------------------------------------------------------
module wb_arb_rr2
  import wb_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default assignment before the case so every path writes gnt;
    // without it a missing branch would infer a latch.
    gnt = 2'b00;
    unique case ({req1, req0})
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == M_INS) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_arb2.sv
// -----------------------------------------------------------------------------
// wb_arb2
//   Two-master to one-slave Wishbone classic arbiter. Sits between the RISC-V
//   BIU (instruction port m0, data port m1) and the SoC interconnect (s).
//   Round-robin grant, held until the slave acks or the owner drops cyc.
//   Every grant is preceded by an IDLE cycle, so consecutive transfers are
//   never merged on the shared bus.
//
//   Parameters:
//     AW, DW       address / data width
//     TIMEOUT_CYC  watchdog limit in grant cycles (WB_ARB_TIMEOUT_EN only)
//
//   Ports:
//     clk_i     in   system clock
//     rst_i     in   asynchronous, active-high reset
//     m0        slv  instruction master (read-only; we/sel/dat_w ignored)
//     m1        slv  data master
//     s         mst  shared downstream bus (all outputs registered)
//     to_err_o  out  sticky watchdog flag (WB_ARB_TIMEOUT_EN only)
//
//   Build option:
//     `define WB_ARB_TIMEOUT_EN  adds the grant watchdog and to_err_o. When
//     it fires, the owner receives a synthesised one-cycle ack carrying
//     TIMEOUT_DAT and the bus cycle is terminated as for a normal ack.
// -----------------------------------------------------------------------------
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef WB_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wb_arb2_if.slv   m0,
  wb_arb2_if.slv   m1,
  wb_arb2_if.mst   s
`ifdef WB_ARB_TIMEOUT_EN
  , output logic   to_err_o
`endif
);

  arb_state_e    state;
  logic          last_gnt;
  logic [1:0]    gnt;
  logic          req0;
  logic          req1;
  logic          bus_ack;
  logic          to_hit;
  logic          term;
  logic          own_cyc;
  logic [DW-1:0] rd_dat;

  // Registered copy of the shared bus; driven onto s below.
  logic          s_cyc_q;
  logic          s_stb_q;
  logic          s_we_q;
  logic [3:0]    s_sel_q;
  logic [AW-1:0] s_adr_q;
  logic [DW-1:0] s_dat_q;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  wb_arb_rr2 u_rr2 (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  // Qualifying with our own strobe makes a late or stray ack harmless.
  assign bus_ack = s.ack & s_stb_q;
  assign term    = bus_ack | to_hit;
  assign own_cyc = (state == GNT1) ? m1.cyc : m0.cyc;

  // Ack routing is combinational so the owner sees it in the slave's cycle.
  assign m0.ack = (state == GNT0) & term;
  assign m1.ack = (state == GNT1) & term;

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0.dat_r = rd_dat;
  assign m1.dat_r = rd_dat;

  assign s.cyc   = s_cyc_q;
  assign s.stb   = s_stb_q;
  assign s.we    = s_we_q;
  assign s.sel   = s_sel_q;
  assign s.adr   = s_adr_q;
  assign s.dat_w = s_dat_q;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] to_cnt;

  // Counter is zero during the first grant cycle, so the watchdog fires in
  // grant cycle TIMEOUT_CYC. A genuine ack in that same cycle wins.
  assign to_hit = (state != IDLE) && (to_cnt == CW'(TIMEOUT_CYC - 1)) && !bus_ack;
  assign rd_dat = to_hit ? DW'(TIMEOUT_DAT) : s.dat_r;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt   <= '0;
      to_err_o <= 1'b0;
    end else begin
      // Every grant starts from IDLE, so clearing there restarts the count.
      if (state == IDLE) to_cnt <= '0;
      else               to_cnt <= to_cnt + 1'b1;
      if (to_hit)        to_err_o <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign rd_dat = s.dat_r;
`endif

  // Single-process FSM; the shared-bus outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: reset clears every bus register asynchronously, so an in-flight
    // cycle vanishes from the shared bus the moment rst_i rises.
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= M_INS;
      s_cyc_q  <= 1'b0;
      s_stb_q  <= 1'b0;
      s_we_q   <= 1'b0;
      s_sel_q  <= 4'h0;
      s_adr_q  <= '0;
      s_dat_q  <= '0;
    end else begin
      // NOTE: nonblocking assignments throughout so every register samples
      // the pre-edge values regardless of statement order.
      unique case (state)
        IDLE: begin
          if (gnt[M_DAT]) begin
            state   <= GNT1;
            s_cyc_q <= 1'b1;
            s_stb_q <= 1'b1;
            s_we_q  <= m1.we;
            s_sel_q <= m1.sel;
            s_adr_q <= m1.adr;
            s_dat_q <= m1.dat_w;
          end else if (gnt[M_INS]) begin
            state   <= GNT0;
            s_cyc_q <= 1'b1;
            s_stb_q <= 1'b1;
            s_we_q  <= 1'b0;
            s_sel_q <= SEL_ALL;
            s_adr_q <= m0.adr;
            s_dat_q <= '0;
          end
        end

        GNT0, GNT1: begin
          if (term) begin
            // Completed transfer: release the bus and rotate priority.
            state    <= IDLE;
            last_gnt <= (state == GNT1) ? M_DAT : M_INS;
            s_cyc_q  <= 1'b0;
            s_stb_q  <= 1'b0;
            s_we_q   <= 1'b0;
            s_sel_q  <= 4'h0;
          end else if (!own_cyc) begin
            // Owner abandoned its cycle: release without rotating priority.
            state   <= IDLE;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            s_we_q  <= 1'b0;
            s_sel_q <= 4'h0;
            s_adr_q <= '0;
            s_dat_q <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          s_cyc_q <= 1'b0;
          s_stb_q <= 1'b0;
          s_we_q  <= 1'b0;
          s_sel_q <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// -----------------------------------------------------------------------------
// tb_wb_arb2
//   Directed self-checking bench for wb_arb2. The bench plays both BIU masters
//   and the downstream slave through three wb_arb2_if instances. Inputs are
//   driven 2 time units after the rising edge, outputs are sampled 1 unit
//   later, well away from either clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_arb2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;

  wb_arb2_if #(.AW(32), .DW(32)) m0_if ();
  wb_arb2_if #(.AW(32), .DW(32)) m1_if ();
  wb_arb2_if #(.AW(32), .DW(32)) s_if ();

`ifdef WB_ARB_TIMEOUT_EN
  logic to_err;
`endif

  wb_arb2 #(
    .AW(32),
    .DW(32)
`ifdef WB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
`ifdef WB_ARB_TIMEOUT_EN
    , .to_err_o (to_err)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic m0_req(input bit on, input logic [31:0] adr);
    m0_if.cyc = on;
    m0_if.stb = on;
    m0_if.adr = adr;
  endtask

  task automatic m1_req(input bit on, input bit we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1_if.cyc   = on;
    m1_if.stb   = on;
    m1_if.we    = we;
    m1_if.sel   = sel;
    m1_if.adr   = adr;
    m1_if.dat_w = dat;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m0_req(1'b0, 32'h0);
    m1_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    s_if.ack   = 1'b0;
    s_if.dat_r = 32'h0;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  // Bounded wait for the shared strobe; an expired budget is a failed check.
  task automatic wait_stb(input string tag);
    int n = 0;
    while (s_if.stb !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, {63'b0, s_if.stb}, 64'd1);
  endtask

  // Slave acks now; the owner must see it with the data, the other must not.
  // After the ack edge the bus must be idle.
  task automatic finish_xfer(input string tag, input bit owner, input logic [31:0] dat);
    s_if.ack   = 1'b1;
    s_if.dat_r = dat;
    #1;
    if (m0_if.ack === 1'b1) ack0_cnt++;
    if (m1_if.ack === 1'b1) ack1_cnt++;
    check({tag, ".ack0"}, {63'b0, m0_if.ack}, {63'b0, (owner == 1'b0)});
    check({tag, ".ack1"}, {63'b0, m1_if.ack}, {63'b0, (owner == 1'b1)});
    check({tag, ".dat"}, {32'b0, owner ? m1_if.dat_r : m0_if.dat_r}, {32'b0, dat});
    tick();
    s_if.ack = 1'b0;
    #1;
    check({tag, ".idle"}, {63'b0, s_if.cyc}, 64'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    m0_if.we = 1'b0; m0_if.sel = 4'h0; m0_if.dat_w = 32'h0;
    do_reset();
    #1;
    check("rst.cyc", {63'b0, s_if.cyc}, 64'd0);
    check("rst.stb", {63'b0, s_if.stb}, 64'd0);
    check("rst.we",  {63'b0, s_if.we},  64'd0);
    check("rst.sel", {60'b0, s_if.sel}, 64'd0);
    check("rst.adr", {32'b0, s_if.adr}, 64'd0);

    // ---------------- single instruction read ----------------
    m0_req(1'b1, 32'h100);
    #1;
    check("t1.latency", {63'b0, s_if.stb}, 64'd0);
    tick();
    check("t1.stb", {63'b0, s_if.stb}, 64'd1);
    check("t1.adr", {32'b0, s_if.adr}, 64'h100);
    check("t1.sel", {60'b0, s_if.sel}, 64'hf);
    check("t1.we",  {63'b0, s_if.we},  64'd0);
    tick();
    check("t1.noack", {63'b0, m0_if.ack}, 64'd0);
    tick();
    finish_xfer("t1", 1'b0, 32'h00000013);
    m0_req(1'b0, 32'h0);
    tick();
    check("t1.noregrant", {63'b0, s_if.cyc}, 64'd0);

    // ---------------- tie on first cycle after reset ----------------
    do_reset();
    m0_req(1'b1, 32'h200);
    m1_req(1'b1, 1'b1, 4'h3, 32'h8000, 32'hA5A5A5A5);
    tick();
    check("t2.m1.adr", {32'b0, s_if.adr},   64'h8000);
    check("t2.m1.we",  {63'b0, s_if.we},    64'd1);
    check("t2.m1.sel", {60'b0, s_if.sel},   64'h3);
    check("t2.m1.dat", {32'b0, s_if.dat_w}, 64'hA5A5A5A5);
    finish_xfer("t2.m1", 1'b1, 32'h0);
    m1_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("t2.m0.adr", {32'b0, s_if.adr}, 64'h200);
    check("t2.m0.we",  {63'b0, s_if.we},  64'd0);
    check("t2.m0.sel", {60'b0, s_if.sel}, 64'hf);
    finish_xfer("t2.m0", 1'b0, 32'h12345678);
    m0_req(1'b0, 32'h0);

    // ---------------- continuous requests: strict alternation ----------------
    ack0_cnt = 0;
    ack1_cnt = 0;
    m0_req(1'b1, 32'h300);
    m1_req(1'b1, 1'b0, 4'hf, 32'h9000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      wait_stb("t3.stb");
      check("t3.order", {32'b0, s_if.adr}, (i % 2 == 0) ? 64'h9000 : 64'h300);
      finish_xfer("t3", (i % 2 == 0), 32'h1000 + i);
    end
    m0_req(1'b0, 32'h0);
    m1_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t3.acks0", ack0_cnt, 64'd4);
    check("t3.acks1", ack1_cnt, 64'd4);

    // ---------------- abort by data master ----------------
    m1_req(1'b1, 1'b0, 4'hf, 32'hA000, 32'h0);
    wait_stb("t4.stb");
    check("t4.adr", {32'b0, s_if.adr}, 64'hA000);
    tick();
    check("t4.wait.ack1", {63'b0, m1_if.ack}, 64'd0);
    m1_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    #1;
    check("t4.abort.cyc", {63'b0, s_if.cyc}, 64'd0);
    check("t4.abort.ack0", {63'b0, m0_if.ack}, 64'd0);
    check("t4.abort.ack1", {63'b0, m1_if.ack}, 64'd0);
    s_if.ack = 1'b1;
    #1;
    check("t4.stray.ack0", {63'b0, m0_if.ack}, 64'd0);
    check("t4.stray.ack1", {63'b0, m1_if.ack}, 64'd0);
    s_if.ack = 1'b0;
    // last_gnt is still m0 from the alternation run, so the tie goes to m1.
    m0_req(1'b1, 32'h400);
    m1_req(1'b1, 1'b0, 4'hf, 32'hA000, 32'h0);
    wait_stb("t4.re.stb");
    check("t4.re.adr", {32'b0, s_if.adr}, 64'hA000);
    finish_xfer("t4.m1", 1'b1, 32'h55);
    m1_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    wait_stb("t4.m0.stb");
    check("t4.m0.adr", {32'b0, s_if.adr}, 64'h400);
    finish_xfer("t4.m0", 1'b0, 32'h66);
    m0_req(1'b0, 32'h0);

    // ---------------- reset mid-transfer ----------------
    m1_req(1'b1, 1'b0, 4'hf, 32'hB000, 32'h0);
    wait_stb("t5.stb");
    finish_xfer("t5.m1", 1'b1, 32'h77);   // last_gnt becomes m1
    m1_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    m0_req(1'b1, 32'h600);
    wait_stb("t5.m0.stb");
    s_if.ack = 1'b1;
    #1;
    check("t5.preack", {63'b0, m0_if.ack}, 64'd1);
    rst_i = 1'b1;
    #1;
    check("t5.rst.cyc", {63'b0, s_if.cyc}, 64'd0);
    check("t5.rst.stb", {63'b0, s_if.stb}, 64'd0);
    check("t5.rst.adr", {32'b0, s_if.adr}, 64'd0);
    check("t5.rst.ack0", {63'b0, m0_if.ack}, 64'd0);
    m0_req(1'b0, 32'h0);
    s_if.ack = 1'b0;
    tick();
    rst_i = 1'b0;
    m0_req(1'b1, 32'h700);
    m1_req(1'b1, 1'b0, 4'hf, 32'hC000, 32'h0);
    tick();
    check("t5.tie.adr", {32'b0, s_if.adr}, 64'hC000);
    finish_xfer("t5.tie", 1'b1, 32'h88);
    m1_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    m0_req(1'b0, 32'h0);

`ifdef WB_ARB_TIMEOUT_EN
    // ---------------- watchdog (TIMEOUT_CYC = 16) ----------------
    do_reset();
    s_if.dat_r = 32'hDEADBEEF;
    m0_req(1'b1, 32'h500);
    wait_stb("t6.stb");
    for (int k = 2; k <= 15; k++) begin
      tick();
      check("t6.noack", {63'b0, m0_if.ack}, 64'd0);
    end
    tick();
    #1;
    check("t6.ack0",   {63'b0, m0_if.ack}, 64'd1);
    check("t6.dat",    {32'b0, m0_if.dat_r}, 64'd0);
    check("t6.ack1",   {63'b0, m1_if.ack}, 64'd0);
    check("t6.err.pre", {63'b0, to_err}, 64'd0);
    tick();
    check("t6.release", {63'b0, s_if.cyc}, 64'd0);
    check("t6.err",     {63'b0, to_err},   64'd1);
    m0_req(1'b0, 32'h0);
    tick();
    check("t6.sticky",  {63'b0, to_err},   64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
